// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU, memory port and register file, and counts retired instructions.
module rv_multicycle_ctrl #(
    parameter int CNT_W          = 32,
    parameter bit TRAP_ON_SYSTEM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic [2:0]       ImmSel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_ifetch,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP
    } class_t;

    state_t           r_state, w_next;
    class_t           r_class, w_dec_class;
    logic             w_dec_ok;
    logic             w_retire;
    logic             r_trap;
    logic [CNT_W-1:0] r_instret;

    // Opcode classification; anything unrecognised (including bits[1:0] != 11) is illegal.
    always_comb begin
        w_dec_class = C_NOP;
        w_dec_ok    = 1'b1;
        case (opcode)
            7'b0110111: w_dec_class = C_LUI;
            7'b0010111: w_dec_class = C_AUIPC;
            7'b1101111: w_dec_class = C_JAL;
            7'b1100111: w_dec_class = C_JALR;
            7'b1100011: w_dec_class = C_BR;
            7'b0000011: w_dec_class = C_LD;
            7'b0100011: w_dec_class = C_ST;
            7'b0010011: w_dec_class = C_OPI;
            7'b0110011: w_dec_class = C_OP;
            7'b0001111: w_dec_class = C_NOP;
            7'b1110011: w_dec_ok    = !TRAP_ON_SYSTEM;
            default:    w_dec_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_class   <= C_NOP;
            r_trap    <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_class <= w_dec_class;
            if (w_next == S_TRAP)
                r_trap <= 1'b1;
            if (w_retire)
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        ImmSel     = 3'b000;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;

        case (r_class)
            C_OPI, C_LD, C_JALR: ImmSel = 3'b000;
            C_ST:                ImmSel = 3'b001;
            C_BR:                ImmSel = 3'b010;
            C_JAL:               ImmSel = 3'b011;
            C_LUI, C_AUIPC:      ImmSel = 3'b100;
            default:             ImmSel = 3'b000;
        endcase

        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: w_next = w_dec_ok ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (r_class)
                    C_LUI: begin alu_src_a = 2'd2; alu_src_b = 1'b1; end
                    C_AUIPC, C_JAL, C_BR: begin alu_src_a = 2'd1; alu_src_b = 1'b1; end
                    C_JALR, C_LD, C_ST: alu_src_b = 1'b1;
                    C_OPI: begin alu_src_b = 1'b1; alu_op = 2'd1; end
                    C_OP:  alu_op = 2'd1;
                    default: ;
                endcase
                // Branch resolves here: the adder already holds the PC-relative target.
                if (r_class == C_BR) begin
                    pc_write = 1'b1;
                    pc_src   = br_cond ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (r_class == C_LD || r_class == C_ST) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_class == C_ST);
                if (mem_ready) begin
                    if (r_class == C_ST) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = (r_class != C_NOP);
                case (r_class)
                    C_LD:   wb_sel = 2'd1;
                    C_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
                    C_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
                    default: ;
                endcase
                pc_write = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase

        // Reset silences every strobe so an in-flight request never completes.
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            w_retire  = 1'b0;
        end
    end

    assign trap    = r_trap;
    assign instret = r_instret;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: inputs change on the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'b0010011;
    logic        br_cond = 1'b0;
    logic        mem_ready = 1'b1;
    logic [2:0]  ImmSel;
    logic        ir_write, pc_write, reg_write, mem_req, mem_we, mem_ifetch, alu_src_b, trap;
    logic [1:0]  pc_src, wb_sel, alu_src_a, alu_op;
    logic [31:0] instret;

    int n_assert = 0;
    int n_fail   = 0;

    rv_multicycle_ctrl #(.CNT_W(32), .TRAP_ON_SYSTEM(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_cond(br_cond), .mem_ready(mem_ready),
        .ImmSel(ImmSel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ifetch(mem_ifetch), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [6:0] op, input logic brc, input logic rdy);
        @(negedge clk);
        rst = r; opcode = op; br_cond = brc; mem_ready = rdy;
        #1;
    endtask

    // Bundled strobe vector {ir_write, pc_write, reg_write, mem_req, mem_we}.
    function automatic logic [4:0] strobes();
        return {ir_write, pc_write, reg_write, mem_req, mem_we};
    endfunction

    localparam logic [6:0] OP_ADDI = 7'b0010011, OP_LW = 7'b0000011, OP_BEQ = 7'b1100011,
                           OP_SW = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

    initial begin
        // Reset held over two edges with mem_ready high: nothing strobes.
        cyc(1, OP_ADDI, 0, 1); chk("rst_strobes_c1", 32'(strobes()), 0);
        cyc(1, OP_ADDI, 0, 1); chk("rst_strobes_c2", 32'(strobes()), 0);

        // ADDI, mem_ready tied high.
        cyc(0, OP_ADDI, 0, 1);
        chk("rel_fetch", {30'd0, mem_req, mem_ifetch}, 32'd3);
        chk("rel_instret", instret, 0);
        chk("rel_trap", 32'(trap), 0);
        chk("addi_irw", 32'(ir_write), 1);
        cyc(0, OP_ADDI, 0, 1); chk("addi_dec_strb", 32'(strobes()), 0);
        cyc(0, OP_ADDI, 0, 1);
        chk("addi_ex_imm", 32'(ImmSel), 0);
        chk("addi_ex_srcb", 32'(alu_src_b), 1);
        chk("addi_ex_srca", 32'(alu_src_a), 0);
        chk("addi_ex_aluop", 32'(alu_op), 1);
        chk("addi_ex_strb", 32'(strobes()), 0);
        cyc(0, OP_ADDI, 0, 1);
        chk("addi_wb_strb", 32'(strobes()), 32'b01100);
        chk("addi_wb_sel", 32'(wb_sel), 0);
        chk("addi_wb_pcsrc", 32'(pc_src), 0);
        chk("addi_wb_instret", instret, 0);

        // LW with two wait cycles in MEM.
        cyc(0, OP_LW, 0, 1);
        chk("lw_instret", instret, 1);
        chk("lw_f_irw", 32'(ir_write), 1);
        cyc(0, OP_LW, 0, 1);
        cyc(0, OP_LW, 0, 0);
        chk("lw_ex_srcb", 32'(alu_src_b), 1);
        chk("lw_ex_aluop", 32'(alu_op), 0);
        chk("lw_ex_req", 32'(mem_req), 0);
        cyc(0, OP_LW, 0, 0);
        chk("lw_m1", {29'd0, mem_req, mem_we, mem_ifetch}, 32'b100);
        chk("lw_m1_regw", 32'(reg_write), 0);
        cyc(0, OP_LW, 0, 0);
        chk("lw_m2", {29'd0, mem_req, mem_we, mem_ifetch}, 32'b100);
        cyc(0, OP_LW, 0, 1);
        chk("lw_m3", {29'd0, mem_req, mem_we, mem_ifetch}, 32'b100);
        cyc(0, OP_LW, 0, 1);
        chk("lw_wb_strb", 32'(strobes()), 32'b01100);
        chk("lw_wb_sel", 32'(wb_sel), 1);

        // BEQ taken.
        cyc(0, OP_BEQ, 1, 1);
        chk("beq1_instret", instret, 2);
        cyc(0, OP_BEQ, 1, 1);
        cyc(0, OP_BEQ, 1, 1);
        chk("beq1_imm", 32'(ImmSel), 2);
        chk("beq1_strb", 32'(strobes()), 32'b01000);
        chk("beq1_pcsrc", 32'(pc_src), 1);
        chk("beq1_srca", 32'(alu_src_a), 1);
        // BEQ not taken.
        cyc(0, OP_BEQ, 0, 1);
        chk("beq0_fetch", {30'd0, mem_req, mem_ifetch}, 32'd3);
        chk("beq0_instret", instret, 3);
        cyc(0, OP_BEQ, 0, 1);
        cyc(0, OP_BEQ, 0, 1);
        chk("beq0_strb", 32'(strobes()), 32'b01000);
        chk("beq0_pcsrc", 32'(pc_src), 0);

        // SW, no wait.
        cyc(0, OP_SW, 0, 1);
        chk("sw_instret", instret, 4);
        cyc(0, OP_SW, 0, 1);
        cyc(0, OP_SW, 0, 1);
        chk("sw_imm", 32'(ImmSel), 1);
        chk("sw_ex_strb", 32'(strobes()), 0);
        cyc(0, OP_SW, 0, 1);
        chk("sw_mem_strb", 32'(strobes()), 32'b01011);
        chk("sw_mem_pcsrc", 32'(pc_src), 0);

        // JAL then JALR.
        cyc(0, OP_JAL, 0, 1);
        chk("jal_instret", instret, 5);
        cyc(0, OP_JAL, 0, 1);
        cyc(0, OP_JAL, 0, 1);
        chk("jal_imm", 32'(ImmSel), 3);
        chk("jal_srca", 32'(alu_src_a), 1);
        cyc(0, OP_JAL, 0, 1);
        chk("jal_wb_sel", 32'(wb_sel), 2);
        chk("jal_pcsrc", 32'(pc_src), 1);
        chk("jal_wb_strb", 32'(strobes()), 32'b01100);
        cyc(0, OP_JALR, 0, 1);
        cyc(0, OP_JALR, 0, 1);
        cyc(0, OP_JALR, 0, 1);
        chk("jalr_imm", 32'(ImmSel), 0);
        chk("jalr_src", {29'd0, alu_src_a, alu_src_b}, 32'b001);
        cyc(0, OP_JALR, 0, 1);
        chk("jalr_wb_sel", 32'(wb_sel), 2);
        chk("jalr_pcsrc", 32'(pc_src), 2);

        // LUI.
        cyc(0, OP_LUI, 0, 1);
        chk("lui_instret", instret, 7);
        cyc(0, OP_LUI, 0, 1);
        cyc(0, OP_LUI, 0, 1);
        chk("lui_imm", 32'(ImmSel), 4);
        chk("lui_src", {29'd0, alu_src_a, alu_src_b}, 32'b101);
        cyc(0, OP_LUI, 0, 1);
        chk("lui_wb_strb", 32'(strobes()), 32'b01100);

        // Illegal opcode: trap is sticky and the core goes silent.
        cyc(0, OP_BAD, 0, 1);
        chk("bad_instret", instret, 8);
        cyc(0, OP_BAD, 0, 1);
        chk("bad_dec_trap", 32'(trap), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, OP_BAD, 1, 1);
            chk($sformatf("trap_hold_%0d", i), {26'd0, trap, strobes()}, 32'b100000);
            chk($sformatf("trap_instret_%0d", i), instret, 8);
        end
        cyc(1, OP_ADDI, 0, 1);
        chk("trap_rst_strb", 32'(strobes()), 0);
        cyc(0, OP_ADDI, 0, 0);
        chk("trap_clr", 32'(trap), 0);
        chk("trap_clr_instret", instret, 0);
        chk("fetch_wait", {27'd0, strobes()}, 32'b00010);
        cyc(0, OP_ADDI, 0, 0);
        chk("fetch_hold", {29'd0, mem_req, mem_ifetch, ir_write}, 32'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
